// File: rtl/ucaspian_tx_encoder.sv
// Frames uCaspian core events (ACK, FIRE, METRIC, TIME) into a byte stream for the host transport.
// Define UCASPIAN_TX_CHECKSUM_EN to append an XOR checksum byte to every packet.
module ucaspian_tx_encoder #(
  parameter int unsigned TIME_BYTES  = 4,
  parameter logic [7:0]  FIRE_OPCODE = 8'h60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        clear_done,
  output logic        ack_sent,
  input  logic        output_fire_waiting,
  input  logic [7:0]  output_fire_addr,
  output logic        output_fire_sent,
  input  logic        metric_send,
  input  logic [7:0]  metric_value,
  output logic        metric_ack,
  input  logic        time_update,
  input  logic [31:0] time_current,
  output logic        time_sent,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic        busy
);

`ifdef UCASPIAN_TX_CHECKSUM_EN
  localparam int unsigned TRAILER = 1;
`else
  localparam int unsigned TRAILER = 0;
`endif
  localparam int unsigned PKT_MAX = TIME_BYTES + 1 + TRAILER;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE, GAP} state_t;
  typedef enum logic [1:0] {SRC_ACK, SRC_FIRE, SRC_METRIC, SRC_TIME} src_t;

  state_t     state, state_next;
  src_t       grant, grant_next;
  logic [7:0] snap [PKT_MAX];
  logic [7:0] load_bytes [PKT_MAX];
  logic [2:0] len, load_len, byte_idx, next_idx;
  logic [7:0] next_byte;
  logic       last;

  assign next_idx = byte_idx + 3'd1;
  assign last     = (byte_idx == len - 3'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= SRC_ACK;
    end else begin
      state <= state_next;
      grant <= grant_next;
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    case (state)
      IDLE: begin
        if (enable && (clear_done || output_fire_waiting || metric_send || time_update)) begin
          state_next = LOAD;
          if (clear_done)               grant_next = SRC_ACK;
          else if (output_fire_waiting) grant_next = SRC_FIRE;
          else if (metric_send)         grant_next = SRC_METRIC;
          else                          grant_next = SRC_TIME;
        end
      end
      LOAD:    state_next = SEND;
      SEND:    if (tx_rdy && last) state_next = DONE;
      DONE:    state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Packet image built from the live source; it is frozen into snap during LOAD.
  always_comb begin
    load_bytes = '{default: '0};
    load_len   = '0;
    case (grant)
      SRC_ACK: begin
        load_bytes[0] = 8'h01;
        load_len      = 3'(1 + TRAILER);
      end
      SRC_FIRE: begin
        load_bytes[0] = FIRE_OPCODE;
        load_bytes[1] = output_fire_addr;
        load_len      = 3'(2 + TRAILER);
      end
      SRC_METRIC: begin
        load_bytes[0] = 8'h70;
        load_bytes[1] = metric_value;
        load_len      = 3'(2 + TRAILER);
      end
      default: begin
        load_bytes[0] = 8'h50;
        for (int unsigned i = 1; i <= TIME_BYTES; i++)
          load_bytes[i] = time_current[8*(TIME_BYTES-i) +: 8];
        load_len = 3'(TIME_BYTES + 1 + TRAILER);
      end
    endcase
  end

`ifdef UCASPIAN_TX_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR of accepted bytes; the final slot carries it instead of a snapshot byte.
  assign next_byte = (next_idx == len - 3'd1) ? (csum ^ tx_data) : snap[next_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        csum <= '0;
    else if (state == LOAD)           csum <= '0;
    else if (state == SEND && tx_rdy) csum <= csum ^ tx_data;
  end
`else
  assign next_byte = snap[next_idx];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_vld   <= 1'b0;
      tx_data  <= '0;
      byte_idx <= '0;
      len      <= '0;
      snap     <= '{default: '0};
    end else begin
      case (state)
        LOAD: begin
          snap     <= load_bytes;
          len      <= load_len;
          byte_idx <= '0;
          tx_data  <= load_bytes[0];
          tx_vld   <= 1'b1;
        end
        SEND: begin
          if (tx_rdy) begin
            if (last) begin
              tx_vld <= 1'b0;
            end else begin
              byte_idx <= next_idx;
              tx_data  <= next_byte;
            end
          end
        end
        default: tx_vld <= 1'b0;
      endcase
    end
  end

  assign ack_sent         = (state == DONE) && (grant == SRC_ACK);
  assign output_fire_sent = (state == DONE) && (grant == SRC_FIRE);
  assign metric_ack       = (state == DONE) && (grant == SRC_METRIC);
  assign time_sent        = (state == DONE) && (grant == SRC_TIME);
  assign busy             = (state != IDLE);

endmodule

// File: tb/tb_ucaspian_tx_encoder.sv
// Directed bench for ucaspian_tx_encoder: packet bytes, pulse timing, priority, backpressure, reset, enable.
// A second instance with TIME_BYTES=2 covers the shortened TIME packet.
module tb_ucaspian_tx_encoder;
  typedef logic [7:0] bq_t[$];

`ifdef UCASPIAN_TX_CHECKSUM_EN
  localparam int unsigned T = 1;
`else
  localparam int unsigned T = 0;
`endif

  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0;
  logic        clear_done, output_fire_waiting, metric_send, time_update, tx_rdy;
  logic [7:0]  output_fire_addr, metric_value;
  logic [31:0] time_current;
  logic        ack_sent, output_fire_sent, metric_ack, time_sent, tx_vld, busy;
  logic [7:0]  tx_data;
  logic        time_update2, rdy2, zero1;
  logic [7:0]  zero8;
  logic        ack2, fire2, metric2, time_sent2, vld2, busy2;
  logic [7:0]  data2;
  logic [4:0]  pulses;

  int unsigned n_vec = 0, n_err = 0, cyc = 0, viol = 0, t0;
  bq_t         rx_q, rx2_q;
  int unsigned rx_cyc[$], pulse_q[$], pulse_cyc[$];

  ucaspian_tx_encoder dut (
    .clk(clk), .reset(reset), .enable(enable),
    .clear_done(clear_done), .ack_sent(ack_sent),
    .output_fire_waiting(output_fire_waiting), .output_fire_addr(output_fire_addr),
    .output_fire_sent(output_fire_sent),
    .metric_send(metric_send), .metric_value(metric_value), .metric_ack(metric_ack),
    .time_update(time_update), .time_current(time_current), .time_sent(time_sent),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .busy(busy)
  );

  ucaspian_tx_encoder #(.TIME_BYTES(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable),
    .clear_done(zero1), .ack_sent(ack2),
    .output_fire_waiting(zero1), .output_fire_addr(zero8), .output_fire_sent(fire2),
    .metric_send(zero1), .metric_value(zero8), .metric_ack(metric2),
    .time_update(time_update2), .time_current(time_current), .time_sent(time_sent2),
    .tx_data(data2), .tx_vld(vld2), .tx_rdy(rdy2), .busy(busy2)
  );

  assign pulses = {time_sent2, time_sent, metric_ack, output_fire_sent, ack_sent};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      if (tx_vld && tx_rdy) begin
        rx_q.push_back(tx_data);
        rx_cyc.push_back(cyc);
      end
      if (vld2 && rdy2) rx2_q.push_back(data2);
      for (int unsigned i = 0; i < 4; i++)
        if (pulses[i]) begin
          pulse_q.push_back(i);
          pulse_cyc.push_back(cyc);
        end
      if ($countones(pulses[3:0]) > 1 || ack2 || fire2 || metric2) viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // body holds the packet bytes right-aligned, first byte most significant.
  task automatic check_pkt(input string tag, input bq_t got, input int unsigned base,
                           input logic [63:0] body, input int unsigned n);
    logic [7:0] b, x;
    x = '0;
    for (int unsigned i = 0; i < n + T; i++) begin
      b = (i < n) ? body[8*(n-1-i) +: 8] : x;
      x ^= b;
      check($sformatf("%s_b%0d", tag, i),
            (int'(base + i) < got.size()) ? {24'h0, got[base+i]} : 32'hFFFF_FFFF, {24'h0, b});
    end
  endtask

  function automatic int unsigned npulse(input int unsigned code);
    int unsigned n = 0;
    foreach (pulse_q[i]) if (pulse_q[i] == code) n++;
    return n;
  endfunction

  task automatic clear_q();
    rx_q.delete(); rx2_q.delete(); rx_cyc.delete(); pulse_q.delete(); pulse_cyc.delete();
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_vld(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = tx_vld;
    end
    check({tag, "_vld_timeout"}, seen, 1);
  endtask

  // Core behaviour: a source level falls one cycle after its completion pulse.
  task automatic wait_pulse_drop(input int unsigned which, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = pulses[which];
    end
    check({tag, "_pulse_timeout"}, seen, 1);
    @(posedge clk); #1;
    case (which)
      0: clear_done = 1'b0;
      1: output_fire_waiting = 1'b0;
      2: metric_send = 1'b0;
      3: time_update = 1'b0;
      default: time_update2 = 1'b0;
    endcase
  endtask

  initial begin
    clear_done = 0; output_fire_waiting = 0; metric_send = 0; time_update = 0;
    output_fire_addr = '0; metric_value = '0; time_current = '0; tx_rdy = 1;
    time_update2 = 0; rdy2 = 1; zero1 = 0; zero8 = '0;

    repeat (3) @(negedge clk);
    check("rst_tx_vld", tx_vld, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {ack_sent, output_fire_sent, metric_ack, time_sent}, 0);
    @(posedge clk); #1;
    reset = 0; enable = 1;
    idle(2);

    // FIRE: latency, back-to-back bytes, single pulse one cycle after the last byte
    clear_q();
    t0 = cyc;
    output_fire_waiting = 1; output_fire_addr = 8'h2A;
    wait_pulse_drop(1, "fire");
    idle(10);
    check("fire_len", rx_q.size(), 2 + T);
    check_pkt("fire", rx_q, 0, 64'h602A, 2);
    check("fire_latency", (rx_cyc.size() > 0) ? rx_cyc[0] - t0 : 32'hFFFF_FFFF, 2);
    check("fire_gapless", (rx_cyc.size() > 1) ? rx_cyc[1] - rx_cyc[0] : 32'hFFFF_FFFF, 1);
    check("fire_npulse", npulse(1), 1);
    check("fire_pulse_time", (pulse_cyc.size() > 0 && rx_cyc.size() == 2 + T) ?
          pulse_cyc[0] - rx_cyc[1+T] : 32'hFFFF_FFFF, 1);

    // Priority: ACK, then FIRE, then TIME (TIME_BYTES=4)
    clear_q();
    clear_done = 1; output_fire_waiting = 1; output_fire_addr = 8'h03;
    time_update = 1; time_current = 32'h0000_0105;
    wait_pulse_drop(0, "prio_ack");
    wait_pulse_drop(1, "prio_fire");
    wait_pulse_drop(3, "prio_time");
    idle(10);
    check("prio_len", rx_q.size(), 8 + 3*T);
    check_pkt("prio_ack", rx_q, 0, 64'h01, 1);
    check_pkt("prio_fire", rx_q, 1 + T, 64'h6003, 2);
    check_pkt("prio_time", rx_q, 3 + 2*T, 64'h50_0000_0105, 5);
    check("prio_order", (pulse_q.size() == 3) ? pulse_q[0]*100 + pulse_q[1]*10 + pulse_q[2] : 999, 13);
    check("prio_spacing", (rx_cyc.size() > 1 + T) ? rx_cyc[1+T] - rx_cyc[T] : 32'hFFFF_FFFF, 5);

    // Backpressure on METRIC: stalls on both header and payload
    clear_q();
    tx_rdy = 0; metric_send = 1; metric_value = 8'h9C;
    wait_vld("bp");
    check("bp_hdr", tx_data, 8'h70);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check($sformatf("bp_stall%0d_data", i), tx_data, 8'h70);
      check($sformatf("bp_stall%0d_vld", i), tx_vld, 1);
    end
    @(posedge clk); #1; tx_rdy = 1;
    @(posedge clk); #1; tx_rdy = 0;
    @(negedge clk);
    check("bp_payload_held", tx_data, 8'h9C);
    @(posedge clk); #1; tx_rdy = 1;
    wait_pulse_drop(2, "bp");
    idle(8);
    check("bp_len", rx_q.size(), 2 + T);
    check_pkt("bp", rx_q, 0, 64'h709C, 2);
    check("bp_npulse", npulse(2), 1);

    // Reset after two TIME bytes, then a fresh TIME packet
    clear_q();
    time_update = 1; time_current = 32'h0000_0105;
    for (int i = 0; i < 100 && rx_q.size() < 2; i++) @(negedge clk);
    check("rst_mid_reached", rx_q.size(), 2);
    @(posedge clk); #1;
    reset = 1; #1;
    check("rst_mid_vld", tx_vld, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_nopulse", npulse(3), 0);
    @(posedge clk); #1;
    reset = 0;
    clear_q();
    wait_pulse_drop(3, "rst_time");
    idle(8);
    check("rst_time_len", rx_q.size(), 5 + T);
    check_pkt("rst_time", rx_q, 0, 64'h50_0000_0105, 5);
    check("rst_time_npulse", npulse(3), 1);

    // TIME_BYTES=2 instance
    clear_q();
    time_update2 = 1; time_current = 32'h0000_0105;
    wait_pulse_drop(4, "time2");
    idle(6);
    check("time2_len", rx2_q.size(), 3 + T);
    check_pkt("time2", rx2_q, 0, 64'h50_0105, 3);

    // enable falls mid-FIRE: packet completes, nothing new until enable returns
    clear_q();
    output_fire_waiting = 1; output_fire_addr = 8'h11;
    wait_vld("en");
    @(posedge clk); #1; enable = 0;
    wait_pulse_drop(1, "en_fire");
    metric_send = 1; metric_value = 8'h5A;
    idle(8);
    @(negedge clk);
    check("en_hold_busy", busy, 0);
    check("en_hold_len", rx_q.size(), 2 + T);
    @(posedge clk); #1; enable = 1;
    wait_pulse_drop(2, "en_metric");
    idle(6);
    check("en_len", rx_q.size(), 4 + 2*T);
    check_pkt("en_fire", rx_q, 0, 64'h6011, 2);
    check_pkt("en_metric", rx_q, 2 + T, 64'h705A, 2);

    check("pulse_onehot", viol, 0);
    check("dut2_idle", busy2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ucaspian_tx_encoder.md
Name: ucaspian_tx_encoder

Overview:
- Serializes uCaspian core events into a byte stream for the host transport (UART/USB FIFO).
- Sits between the core's output-side handshakes and the I/O byte sink.
- Sources: clear_done, output_fire_waiting, metric_send and time_update.
- For each source it emits a framed packet, then returns the matching one-cycle completion pulse (ack_sent, output_fire_sent, metric_ack, time_sent).
- It is the transmit counterpart of the packet decoder that feeds the core.

Parameters:
- TIME_BYTES, 4: bytes of time_current sent in a TIME packet, MSB first; legal 1..4; upper bytes of the 32-bit value are dropped.
- FIRE_OPCODE, 8'h60: header byte of a FIRE packet.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  when low, no new packet is granted; a packet already in flight completes
- clear_done  in  1  core clear-complete level
- ack_sent  out  1  one-cycle pulse after the ACK packet's last byte is accepted
- output_fire_waiting  in  1  core output fire pending (level)
- output_fire_addr  in  8  neuron id of the pending fire
- output_fire_sent  out  1  one-cycle pulse after the FIRE packet completes
- metric_send  in  1  metric value valid (level)
- metric_value  in  8  metric byte
- metric_ack  out  1  one-cycle pulse after the METRIC packet completes; the decoder drops metric_read on it
- time_update  in  1  core time advanced (level)
- time_current  in  32  core time
- time_sent  out  1  one-cycle pulse after the TIME packet completes
- tx_data  out  8  byte to transport
- tx_vld  out  1  tx_data valid
- tx_rdy  in  1  transport accepts the byte when tx_vld && tx_rdy
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state=IDLE; tx_vld=0; tx_data=0; busy=0; all completion pulses=0; snapshot regs=0.
- Packet formats:
  - ACK = 8'h01
  - FIRE = FIRE_OPCODE, addr
  - METRIC = 8'h70, value
  - TIME = 8'h50, then TIME_BYTES bytes of time_current, MSB first
- FSM states: IDLE, LOAD, SEND, DONE, GAP.
- IDLE: when enable=1 and any source is pending, grant by fixed priority clear_done > output_fire_waiting > metric_send > time_update, then go to LOAD.
- LOAD (1 cycle):
  - Snapshot the header, payload, packet length (1..TIME_BYTES+1) and grant id into internal registers.
  - Source changes after this cycle do not affect the packet.
  - byte_idx=0; go to SEND.
- SEND:
  - tx_vld=1; tx_data=snapshot[byte_idx].
  - tx_data and tx_vld are registered and stable until accepted.
  - On tx_vld && tx_rdy: if byte_idx==len-1, go to DONE; else byte_idx+1.
  - A back-to-back accept gives 1 byte/cycle with no bubbles inside a packet.
  - tx_rdy low holds state indefinitely.
- DONE (1 cycle): tx_vld=0; pulse the completion output for the granted source; go to GAP.
- GAP (1 cycle):
  - No arbitration, because the core's level drops one cycle after the pulse; prevents re-sending the same event. Go to IDLE.
  - Minimum spacing: header of the next packet appears ≥3 cycles after the last byte of the previous one is accepted.
- Latency: source asserted in IDLE → first tx_vld 2 cycles later (IDLE grant edge, LOAD edge).
- Simultaneous sources: the lower-priority source waits; its level must stay high and it is serviced later. No source is lost while its level is held.
- Starvation: time_update cannot block fires, because the core does not advance time while a fire is waiting.
- Source deasserts between grant and DONE: the packet is still sent from the snapshot and the pulse is still issued.
- enable falling mid-packet: the packet finishes; the FSM then stays in IDLE until enable=1.
- Reset mid-packet: abort immediately; tx_vld=0 asynchronously. Partial packets are the transport's concern.
- Only one completion pulse is ever high in a given cycle.

Optional Feature:
- Macro: UCASPIAN_TX_CHECKSUM_EN.
- Defined:
  - Each packet gets one trailing byte = XOR of all preceding bytes of that packet.
  - Packet length +1.
  - The checksum is computed incrementally as bytes are accepted and sent as the final SEND byte.
  - The completion pulse follows acceptance of the checksum byte.
- Undefined: no trailer, no checksum register, lengths as listed in Behaviour.

Test Plan:
- FIRE: output_fire_waiting=1, addr=8'h2A, tx_rdy=1 → bytes 60,2A on consecutive cycles; output_fire_sent pulses once, 1 cycle after 2A is accepted; no second packet while waiting falls.
- TIME: time_update=1, time_current=32'h0000_0105, TIME_BYTES=4 → 50,00,00,01,05; one time_sent pulse. With TIME_BYTES=2 → 50,01,05.
- Priority: clear_done, fire (addr 03) and time_update asserted together → ACK 01, then 60,03, then TIME; pulses in order ack_sent, output_fire_sent, time_sent.
- Backpressure: METRIC value 8'h9C with tx_rdy toggling 1,0,0,1 → tx_data stable at 70 while stalled, then 9C; exactly one metric_ack.
- Reset mid-TIME after 2 bytes → tx_vld=0 and busy=0 immediately; no time_sent; a fresh TIME packet is sent after release while time_update stays high.
- UCASPIAN_TX_CHECKSUM_EN defined, FIRE addr 8'h2A → 60,2A,4A; pulse after 4A is accepted.
